// File: rtl/timer_ctrl.sv
// timer_ctrl: control stage for a W-bit up-counter.
// Holds the CPU-visible register file (CTRL, PRESC, RELOAD, STATUS, VALUE),
// sequences the counter through IDLE/LOAD/RUN, paces its enable with a
// prescaler, and turns counter overflow into a latched, maskable interrupt.
module timer_ctrl #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic          rd,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          cnt_en,
  output logic          cnt_we,
  output logic [W-1:0]  cnt_data,
  input  logic [W-1:0]  cnt_value,
  input  logic          cnt_overflow,
  output logic          irq
);

  // Register addresses.
  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_PRESC  = AW'(1);
  localparam logic [AW-1:0] A_RELOAD = AW'(2);
  localparam logic [AW-1:0] A_STATUS = AW'(3);
  localparam logic [AW-1:0] A_VALUE  = AW'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  // Software-visible configuration and status.
  logic           auto_q;
  logic           irq_en_q;
  logic           pend_q;
  logic [W-1:0]   presc_q;
  logic [W-1:0]   reload_q;

  // Internal sequencing state.
  logic [W-1:0]   presc_cnt_q;
  logic           ovf_prev_q;

  // Decoded strobes and derived conditions.
  logic           wr_ctrl;
  logic           wr_status;
  logic           start_req;
  logic           stop_req;
  logic           running;
  logic           presc_hit;
  logic           ovf_edge;
  logic [W-1:0]   rd_mux;

  assign wr_ctrl   = wr && (addr == A_CTRL);
  assign wr_status = wr && (addr == A_STATUS);
  assign start_req = wr_ctrl && wdata[0];
  assign stop_req  = wr_ctrl && !wdata[0];

  // RUNNING is simply "the timer is not idle"; LOAD counts as running.
  assign running   = (state != IDLE);

  // The prescaler compares against the live PRESC register, so a PRESC
  // write during RUN is honoured at the next compare.
  assign presc_hit = (presc_cnt_q == presc_q);

  // Only a rising edge of overflow seen while counting is an event;
  // edges during IDLE or LOAD are deliberately dropped.
  assign ovf_edge  = cnt_overflow && !ovf_prev_q && (state == RUN);

  // The counter is always offered RELOAD; cnt_we decides when it is taken.
  assign cnt_data  = reload_q;

  assign irq       = pend_q && irq_en_q;

  // State register.
  // NOTE: sequential logic uses non-blocking assignments and an async
  // reset in the sensitivity list so outputs drop the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and counter strobes.
  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_we    = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_we = 1'b1;
        // A stop written during the single LOAD cycle still wins.
        if (stop_req) state_nxt = IDLE;
        else          state_nxt = RUN;
      end
      RUN: begin
        cnt_en = presc_hit;
        // Stop has priority over an overflow reload; a START write while
        // already running does not restart the count.
        if (stop_req)      state_nxt = IDLE;
        else if (ovf_edge) state_nxt = auto_q ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration registers written from the CPU side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
      presc_q  <= '0;
      reload_q <= '0;
    end else if (wr) begin
      case (addr)
        A_CTRL: begin
          auto_q   <= wdata[1];
          irq_en_q <= wdata[2];
        end
        A_PRESC:  presc_q  <= wdata;
        A_RELOAD: reload_q <= wdata;
        default: ;
      endcase
    end
  end

  // Pending flag: an overflow event beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        pend_q <= 1'b0;
    else if (ovf_edge)              pend_q <= 1'b1;
    else if (wr_status && wdata[0]) pend_q <= 1'b0;
  end

  // Overflow history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_prev_q <= 1'b0;
    else     ovf_prev_q <= cnt_overflow;
  end

  // Prescaler: cleared on LOAD, free-runs modulo 2^W in RUN, and restarts
  // on a match. Lowering PRESC below the current count therefore wraps
  // all the way around before the next match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
    end else if (state == LOAD) begin
      presc_cnt_q <= '0;
    end else if (state == RUN) begin
      if (presc_hit) presc_cnt_q <= '0;
      else           presc_cnt_q <= presc_cnt_q + 1'b1;
    end
  end

  // Read-data selection; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:   rd_mux = {{(W-3){1'b0}}, irq_en_q, auto_q, running};
      A_PRESC:  rd_mux = presc_q;
      A_RELOAD: rd_mux = reload_q;
      A_STATUS: rd_mux = {{(W-1){1'b0}}, pend_q};
      A_VALUE:  rd_mux = cnt_value;
      default:  rd_mux = '0;
    endcase
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (rd) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus a randomized phase for timer_ctrl,
// driving a behavioural 16-bit up-counter and comparing every cycle against
// a transaction-level reference model of the timer peripheral.
module tb_timer_ctrl;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          wr;
  logic          rd;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          cnt_en;
  logic          cnt_we;
  logic [W-1:0]  cnt_data;
  logic [W-1:0]  cnt_value;
  logic          cnt_overflow;
  logic          irq;

  always #5 clk = ~clk;

  timer_ctrl #(.W(W), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .wr           (wr),
    .rd           (rd),
    .wdata        (wdata),
    .rdata        (rdata),
    .cnt_en       (cnt_en),
    .cnt_we       (cnt_we),
    .cnt_data     (cnt_data),
    .cnt_value    (cnt_value),
    .cnt_overflow (cnt_overflow),
    .irq          (irq)
  );

  // The 16-bit up-counter the controller drives: load has priority over
  // increment; overflow pulses for one cycle when an increment wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_value    <= '0;
      cnt_overflow <= 1'b0;
    end else begin
      cnt_overflow <= 1'b0;
      if (cnt_we) begin
        cnt_value <= cnt_data;
      end else if (cnt_en) begin
        cnt_value    <= cnt_value + 1'b1;
        cnt_overflow <= (cnt_value == '1);
      end
    end
  end

  // ---------------- reference model ----------------
  // mode: 0 stopped, 1 loading, 2 counting
  int m_mode, m_presc, m_reload, m_tick, m_val, m_rdata;
  bit m_auto, m_ien, m_pend, m_ovf, m_ovf_prev;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit obs_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_presc = 0; m_reload = 0; m_tick = 0; m_val = 0; m_rdata = 0;
    m_auto = 0; m_ien = 0; m_pend = 0; m_ovf = 0; m_ovf_prev = 0;
  endtask

  function automatic bit model_en();
    return (m_mode == 2) && (m_tick == m_presc);
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step(input int a, input bit w, input bit r, input int d);
    bit wc, en, ld, ev;
    wc = w && (a == 0);
    en = model_en();
    ld = (m_mode == 1);
    ev = m_ovf && !m_ovf_prev && (m_mode == 2);
    if (r) begin
      case (a)
        0: m_rdata = (int'(m_ien) << 2) + (int'(m_auto) << 1) + int'(m_mode != 0);
        1: m_rdata = m_presc;
        2: m_rdata = m_reload;
        3: m_rdata = int'(m_pend);
        4: m_rdata = m_val;
        default: m_rdata = 0;
      endcase
    end
    m_ovf_prev = m_ovf;
    if (ld) begin
      m_val = m_reload; m_ovf = 0;
    end else if (en) begin
      m_ovf = (m_val == 65535);
      m_val = (m_val + 1) % 65536;
    end else begin
      m_ovf = 0;
    end
    if (ev) m_pend = 1;
    else if (w && a == 3 && d[0]) m_pend = 0;
    if (ld) m_tick = 0;
    else if (m_mode == 2) m_tick = en ? 0 : (m_tick + 1) % 65536;
    case (m_mode)
      0: if (wc && d[0]) m_mode = 1;
      1: m_mode = (wc && !d[0]) ? 0 : 2;
      default: begin
        if (wc && !d[0]) m_mode = 0;
        else if (ev) m_mode = m_auto ? 1 : 0;
      end
    endcase
    if (wc) begin m_auto = d[1]; m_ien = d[2]; end
    if (w && a == 1) m_presc = d & 16'hFFFF;
    if (w && a == 2) m_reload = d & 16'hFFFF;
  endtask

  // One bus cycle: drive, check strobes, clock, check registered results.
  task automatic tick(input int a, input bit w, input bit r, input int d);
    addr = AW'(a); wr = w; rd = r; wdata = W'(d);
    check("cnt_en", cnt_en, model_en());
    check("cnt_we", cnt_we, m_mode == 1);
    if (m_mode == 1) check("cnt_data", cnt_data, m_reload);
    obs_en = cnt_en;
    @(posedge clk); #1;
    cyc++;
    model_step(a, w, r, d);
    wr = 1'b0; rd = 1'b0;
    check("rdata", rdata, m_rdata);
    check("irq", irq, m_pend && m_ien);
    check("cnt_value", cnt_value, m_val);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first_en, second_en, n;
    bit seen;
    logic [W-1:0] v1;

    rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0;
    #2;
    check("reset_rdata", rdata, 0);
    check("reset_en", cnt_en, 0);
    check("reset_we", cnt_we, 0);
    check("reset_irq", irq, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Single-shot from near the top, no interrupt enable.
    tick(2, 1, 0, 16'hFFFD);
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 1);
    check("t2_load_we", cnt_we, 1);
    check("t2_load_data", cnt_data, 16'hFFFD);
    pulses = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (cnt_overflow) begin seen = 1; break; end
      tick(0, 0, 0, 0);
      if (obs_en) pulses++;
    end
    check("t2_ovf_seen", seen, 1);
    check("t2_pulses", pulses, 3);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    check("t2_ctrl", rdata, 0);
    tick(3, 0, 1, 0);
    check("t2_pend", rdata, 1);
    check("t2_irq", irq, 0);
    tick(3, 1, 0, 1);

    // Prescaled auto-reload with interrupt enabled.
    tick(1, 1, 0, 3);
    tick(2, 1, 0, 16'hFFFE);
    tick(0, 1, 0, 7);
    first_en = -1; second_en = -1; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (cnt_overflow) begin seen = 1; break; end
      tick(0, 0, 0, 0);
      if (obs_en) begin
        if (first_en < 0) first_en = cyc;
        else if (second_en < 0) second_en = cyc;
      end
    end
    check("t3_ovf_seen", seen, 1);
    check("t3_en_gap", second_en - first_en, 4);
    tick(0, 0, 0, 0);
    check("t3_irq", irq, 1);
    check("t3_reload_we", cnt_we, 1);
    check("t3_reload_data", cnt_data, 16'hFFFE);
    seen = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (cnt_overflow) begin seen = 1; break; end
      tick(0, 0, 0, 0);
      n++;
    end
    check("t3_ovf2_seen", seen, 1);

    // Asynchronous reset in the middle of RUN.
    tick(0, 0, 1, 0);
    #3 rst = 1'b1;
    #1;
    check("t1_en", cnt_en, 0);
    check("t1_we", cnt_we, 0);
    check("t1_irq", irq, 0);
    check("t1_rdata", rdata, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    tick(0, 0, 1, 0);
    check("t1_ctrl", rdata, 0);

    // Clear racing an overflow edge, then a clean clear.
    tick(1, 1, 0, 0);
    tick(2, 1, 0, 16'hFFFE);
    tick(0, 1, 0, 7);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (cnt_overflow) begin seen = 1; break; end
      tick(0, 0, 0, 0);
    end
    check("t4_ovf_seen", seen, 1);
    tick(3, 1, 0, 1);
    check("t4_set_wins", irq, 1);
    tick(3, 1, 0, 1);
    check("t4_cleared", irq, 0);
    tick(3, 0, 1, 0);
    check("t4_status", rdata, 0);
    tick(0, 1, 0, 0);

    // Stop freezes the counter.
    tick(2, 1, 0, 16'h1000);
    tick(0, 1, 0, 3);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    check("t5_en_off", cnt_en, 0);
    tick(4, 0, 1, 0);
    v1 = rdata;
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    tick(4, 0, 1, 0);
    check("t5_value_frozen", rdata, v1);

    // Unmapped addresses.
    tick(1, 1, 0, 16'h0012);
    tick(2, 1, 0, 16'h0034);
    tick(0, 1, 0, 6);
    tick(6, 0, 1, 0);
    check("t6_rd6", rdata, 0);
    tick(7, 1, 0, 16'hFFFF);
    tick(0, 0, 1, 0);
    check("t6_ctrl", rdata, 6);
    tick(1, 0, 1, 0);
    check("t6_presc", rdata, 16'h0012);
    tick(2, 0, 1, 0);
    check("t6_reload", rdata, 16'h0034);
    tick(3, 0, 1, 0);
    check("t6_status", rdata, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1: if (m_mode != 1) tick(0, 1, 0, int'($urandom_range(0, 7)));
              else tick(0, 0, 0, 0);
        2: if (m_mode != 2) tick(1, 1, 0, int'($urandom_range(0, 3)));
           else tick(1, 0, 1, 0);
        3: tick(2, 1, 0, 16'hFFF0 + int'($urandom_range(0, 15)));
        4: tick(3, 1, 0, int'($urandom_range(0, 1)));
        5: tick(int'($urandom_range(4, 7)), 1, 0, int'($urandom_range(0, 65535)));
        6, 7: tick(int'($urandom_range(0, 7)), 0, 1, 0);
        default: tick(0, 0, 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
